mmu_dma_engine: RTL and testbench

- Bus initiator driving the MMU's address/mode/data interface; copies a block of 32-bit words from a source to a destination address range.
- Sits between the control logic (CPU or sequencer, via start/busy/done) and the MMU.
- Uses the same single-port, word-addressed, mode-selected protocol the MMU responds to. Read data returns from the MMU's registered output.

---
 rtl/mmu_dma_engine.sv | 181 ++++++++++++++++++
 tb/tb_mmu_dma_engine.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mmu_dma_engine.sv
// Block-copy DMA initiator for the single-port, word-addressed MMU bus.
// Optional fill mode (constant pattern writes) is enabled with `define DMA_FILL_EN.
module mmu_dma_engine #(
    parameter int READ_LATENCY = 1,
    parameter int LEN_WIDTH    = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_WIDTH-1:0] length,
`ifdef DMA_FILL_EN
    input  logic                 fill_mode,
    input  logic [31:0]          fill_value,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          bus_address,
    output logic                 bus_mode,
    output logic [31:0]          bus_write_data,
    input  logic [31:0]          bus_read_data
);

    localparam int CW = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [31:0]          src_ptr_q, src_ptr_d;
    logic [31:0]          dst_ptr_q, dst_ptr_d;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic [CW-1:0]        wait_q, wait_d;
    logic [31:0]          data_q, data_d;
    logic                 fill_q, fill_d;

    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [31:0]          addr_q, addr_d;
    logic                 mode_q, mode_d;
    logic [31:0]          wdata_q, wdata_d;

    // Transfer sequencing: next state, pointers, word counter and data latch.
    always_comb begin
        state_d     = state_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        remaining_d = remaining_q;
        wait_d      = wait_q;
        data_d      = data_q;
        fill_d      = fill_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length != {LEN_WIDTH{1'b0}}) begin
                        src_ptr_d   = src_addr;
                        dst_ptr_d   = dst_addr;
                        remaining_d = length;
`ifdef DMA_FILL_EN
                        fill_d = fill_mode;
                        if (fill_mode) begin
                            data_d  = fill_value;
                            state_d = S_WRITE;
                        end else begin
                            state_d = S_READ;
                        end
`else
                        fill_d  = 1'b0;
                        state_d = S_READ;
`endif
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                wait_d  = CW'(READ_LATENCY);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Last latency cycle: the MMU's registered read data is valid now.
                if (wait_q <= CW'(1)) begin
                    data_d  = bus_read_data;
                    state_d = S_WRITE;
                end else begin
                    wait_d  = wait_q - CW'(1);
                    state_d = S_WAIT;
                end
            end
            S_WRITE: begin
                src_ptr_d   = src_ptr_q + 32'd1;
                dst_ptr_d   = dst_ptr_q + 32'd1;
                remaining_d = remaining_q - LEN_WIDTH'(1);
                if (remaining_q == LEN_WIDTH'(1)) begin
                    state_d = S_DONE;
                end else if (fill_q) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus and status outputs are decoded from the next state so they register with it.
    always_comb begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        mode_d  = 1'b0;
        addr_d  = 32'h0000_0000;
        wdata_d = wdata_q;
        case (state_d)
            S_READ, S_WAIT: begin
                busy_d = 1'b1;
                addr_d = src_ptr_d;
            end
            S_WRITE: begin
                busy_d  = 1'b1;
                mode_d  = 1'b1;
                addr_d  = dst_ptr_d;
                wdata_d = data_d;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer and drops bus_mode at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            src_ptr_q   <= 32'h0000_0000;
            dst_ptr_q   <= 32'h0000_0000;
            remaining_q <= {LEN_WIDTH{1'b0}};
            wait_q      <= {CW{1'b0}};
            data_q      <= 32'h0000_0000;
            fill_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= 32'h0000_0000;
            mode_q      <= 1'b0;
            wdata_q     <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            remaining_q <= remaining_d;
            wait_q      <= wait_d;
            data_q      <= data_d;
            fill_q      <= fill_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            addr_q      <= addr_d;
            mode_q      <= mode_d;
            wdata_q     <= wdata_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign bus_address    = addr_q;
    assign bus_mode       = mode_q;
    assign bus_write_data = wdata_q;

endmodule

// File: tb/tb_mmu_dma_engine.sv
// Directed self-checking bench for mmu_dma_engine with a behavioural MMU (read latency 1).
module tb_mmu_dma_engine;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = 32'h0;
    logic [31:0] dst_addr = 32'h0;
    logic [15:0] length = 16'h0;
    logic        busy, done, bus_mode;
    logic [31:0] bus_address, bus_write_data;
    logic [31:0] bus_read_data = 32'h0;
`ifdef DMA_FILL_EN
    logic        fill_mode = 1'b0;
    logic [31:0] fill_value = 32'h0;
`endif

    int checks = 0;
    int failures = 0;

    mmu_dma_engine #(.READ_LATENCY(1), .LEN_WIDTH(16)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .length         (length),
`ifdef DMA_FILL_EN
        .fill_mode      (fill_mode),
        .fill_value     (fill_value),
`endif
        .busy           (busy),
        .done           (done),
        .bus_address    (bus_address),
        .bus_mode       (bus_mode),
        .bus_write_data (bus_write_data),
        .bus_read_data  (bus_read_data)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    function automatic logic [63:0] written(input logic [31:0] a);
        return mem.exists(a) ? 64'd1 : 64'd0;
    endfunction

    // MMU model: registered read output, write on the edge while bus_mode=1.
    always @(posedge clock) begin
        bus_read_data <= rd(bus_address);
        if (bus_mode) mem[bus_address] = bus_write_data;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                            input int mid_cyc, output int done_cyc, output int first_wr,
                            output int last_wr, output int nwr, output int nbusy,
                            output logic [31:0] last_rd);
        done_cyc = -1; first_wr = -1; last_wr = -1; nwr = 0; nbusy = 0;
        last_rd = 32'hDEAD_DEAD;
        @(negedge clock);
        src_addr = s; dst_addr = d; length = l; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            if (mid_cyc > 0 && n == mid_cyc) begin
                start = 1'b1; src_addr = 32'h600; dst_addr = 32'h700; length = 16'd1;
            end
            if (mid_cyc > 0 && n == mid_cyc + 3) start = 1'b0;
            if (busy) nbusy++;
            if (bus_mode) begin
                nwr++;
                if (first_wr < 0) first_wr = n;
                last_wr = n;
            end
            if (busy && !bus_mode) last_rd = bus_address;
            if (done) begin
                done_cyc = n;
                break;
            end
            @(negedge clock);
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic [31:0]      src;
        logic [31:0]      dst;
        logic [15:0]      len;
        logic [31:0]      base;
        int               exp_first;
        int               exp_last;
        int               exp_done;
        int               exp_busy;
        logic [31:0]      exp_rd;
        logic [3:0][31:0] exp_w;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int dc, fw, lw, nw, nb;
        logic [31:0] lr;
        logic [31:0] a;
        logic saw_done;

        vecs[0] = '{32'h50, 32'h60, 16'd4, 32'hA0, 3, 12, 13, 12, 32'h53,
                    {32'hA3, 32'hA2, 32'hA1, 32'hA0}};
        vecs[1] = '{32'h100, 32'h200, 16'd1, 32'h11, 3, 3, 4, 3, 32'h100,
                    {32'h0, 32'h0, 32'h0, 32'h11}};
        vecs[2] = '{32'h10, 32'h11, 16'd3, 32'h30, 3, 9, 10, 9, 32'h12,
                    {32'h0, 32'h30, 32'h30, 32'h30}};
        vecs[3] = '{32'hFFFF_FFFF, 32'h300, 16'd2, 32'h77, 3, 6, 7, 6, 32'h0,
                    {32'h0, 32'h0, 32'h78, 32'h77}};

        repeat (3) @(negedge clock);
        chk("reset_outputs", {26'd0, busy, done, bus_mode, bus_address, bus_write_data[0]},
            64'd0);
        chk("reset_wdata", {32'd0, bus_write_data}, 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < int'(vecs[v].len); i++) begin
                a = vecs[v].src + 32'(i);
                mem[a] = vecs[v].base + 32'(i);
            end
            run_xfer(vecs[v].src, vecs[v].dst, vecs[v].len, 0, dc, fw, lw, nw, nb, lr);
            chk($sformatf("v%0d_done_cycle", v), 64'(dc), 64'(vecs[v].exp_done));
            chk($sformatf("v%0d_first_write", v), 64'(fw), 64'(vecs[v].exp_first));
            chk($sformatf("v%0d_last_write", v), 64'(lw), 64'(vecs[v].exp_last));
            chk($sformatf("v%0d_write_count", v), 64'(nw), 64'(vecs[v].len));
            chk($sformatf("v%0d_busy_cycles", v), 64'(nb), 64'(vecs[v].exp_busy));
            chk($sformatf("v%0d_last_read_addr", v), 64'(lr), 64'(vecs[v].exp_rd));
            for (int i = 0; i < int'(vecs[v].len); i++) begin
                a = vecs[v].dst + 32'(i);
                chk($sformatf("v%0d_dst_word%0d", v, i), 64'(rd(a)), 64'(vecs[v].exp_w[i]));
            end
            @(negedge clock);
            chk($sformatf("v%0d_done_one_cycle", v), {62'd0, done, busy}, 64'd0);
        end

        // Zero-length request: immediate done, no bus activity.
        run_xfer(32'h40, 32'h41, 16'd0, 0, dc, fw, lw, nw, nb, lr);
        chk("len0_done_cycle", 64'(dc), 64'd1);
        chk("len0_writes", 64'(nw), 64'd0);
        chk("len0_busy", 64'(nb), 64'd0);

        // start re-asserted with other operands mid-transfer must be ignored.
        for (int i = 0; i < 4; i++) mem[32'h400 + 32'(i)] = 32'hC0 + 32'(i);
        run_xfer(32'h400, 32'h500, 16'd4, 5, dc, fw, lw, nw, nb, lr);
        chk("mid_done_cycle", 64'(dc), 64'd13);
        chk("mid_write_count", 64'(nw), 64'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("mid_dst_word%0d", i), 64'(rd(32'h500 + 32'(i))), 64'(32'hC0 + 32'(i)));
        chk("mid_no_second_xfer", written(32'h700), 64'd0);
        @(negedge clock);

        // Reset during the WAIT of word 1 (second word) of a 4-word copy.
        for (int i = 0; i < 4; i++) mem[32'h800 + 32'(i)] = 32'hE0 + 32'(i);
        @(negedge clock);
        src_addr = 32'h800; dst_addr = 32'h900; length = 16'd4; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        chk("abort_in_wait", {31'd0, busy, bus_address}, {31'd0, 1'b1, 32'h801});
        reset_n = 1'b0;
        #1;
        chk("abort_outputs", {29'd0, busy, done, bus_mode, bus_address}, 64'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (done || bus_mode || busy) saw_done = 1'b1;
        end
        chk("abort_quiet", {63'd0, saw_done}, 64'd0);
        chk("abort_word0", 64'(rd(32'h900)), 64'hE0);
        chk("abort_word1_unwritten", written(32'h901), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        run_xfer(32'h802, 32'hA00, 16'd1, 0, dc, fw, lw, nw, nb, lr);
        chk("post_reset_done", 64'(dc), 64'd4);
        chk("post_reset_word", 64'(rd(32'hA00)), 64'hE2);

`ifdef DMA_FILL_EN
        @(negedge clock);
        fill_mode = 1'b1; fill_value = 32'hDEAD_BEEF;
        run_xfer(32'h0, 32'h80, 16'd3, 0, dc, fw, lw, nw, nb, lr);
        fill_mode = 1'b0; fill_value = 32'h0;
        chk("fill_done_cycle", 64'(dc), 64'd4);
        chk("fill_first_write", 64'(fw), 64'd1);
        chk("fill_write_count", 64'(nw), 64'd3);
        chk("fill_no_reads", 64'(lr), 64'hDEAD_DEAD);
        for (int i = 0; i < 3; i++)
            chk($sformatf("fill_word%0d", i), 64'(rd(32'h80 + 32'(i))), 64'hDEAD_BEEF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
